// File: rtl/memory_access_pkg.sv
// Shared types for the MA pipeline stage: opcodes, funct3 encodings,
// the control word carried down the pipe and the MA handshake state.
package memory_access_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       load_regfile;
        logic [4:0] rd;
    } rv32i_control_word;

    // MA handshake state kept as plain constants for older tools
    typedef logic [0:0] ma_state_t;
    localparam ma_state_t MA_IDLE = 1'b0;
    localparam ma_state_t MA_WAIT = 1'b1;

endpackage

// File: rtl/memory_access_load_align.sv
// Load data extraction: shifts the cache word down to the addressed byte
// lane and sign- or zero-extends according to the load funct3.
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted_s;

    // Select the addressed lane and extend it to a full word
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (funct3)
            LB:      result = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      result = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LW:      result = rdata;
            LBU:     result = {24'h00_0000, shifted_s[7:0]};
            LHU:     result = {16'h0000, shifted_s[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MA stage of the RV32I pipe: issues data-cache requests, stalls the front
// of the pipe until the cache responds, aligns store/load data and
// registers the result into MA/WB (also the EX forwarding source).
module memory_access
    import memory_access_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  rv32i_control_word ctrl_word_in,
    input  logic [31:0]       instruction_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    input  logic              br_en_in,
    input  logic [3:0]        mem_byte_enable_in,
    input  logic [1:0]        addr_offset_in,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              MA_stall,
    output logic              misalign,
    output rv32i_control_word mem_wb,
    output logic [31:0]       mem_wb_data,
    output logic [31:0]       instruction_out,
    output logic [31:0]       PC_out,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [1:0]        rst_sync_r;
    logic              run_s;
    logic [2:0]        funct3_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              misaligned_s;
    logic              mem_op_s;
    logic              is_slt_s;
    logic [31:0]       load_data_s;
    logic [31:0]       wb_data_s;
    ma_state_t         state_r;
    ma_state_t         state_next_s;
    rv32i_control_word mem_wb_r;
    logic [31:0]       mem_wb_data_r;
    logic [31:0]       instruction_r;
    logic [31:0]       pc_r;
    logic              misalign_r;
    logic [PERF_W-1:0] stall_cycles_r;

    // Reset asserts immediately, releases two edges later on the clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_s = rst_sync_r[1];

    // Classify the instruction and detect accesses the cache cannot take
    always_comb begin
        funct3_s     = instruction_in[14:12];
        is_load_s    = (ctrl_word_in.opcode == OP_LOAD);
        is_store_s   = (ctrl_word_in.opcode == OP_STORE);
        is_slt_s     = ((ctrl_word_in.opcode == OP_REG) || (ctrl_word_in.opcode == OP_IMM)) &&
                       ((funct3_s == F3_SLT) || (funct3_s == F3_SLTU));
        misaligned_s = 1'b0;
        if (is_load_s) begin
            case (funct3_s)
                LW:      misaligned_s = (addr_offset_in != 2'b00);
                LH, LHU: misaligned_s = (addr_offset_in == 2'b11);
                default: misaligned_s = 1'b0;
            endcase
        end else if (is_store_s) begin
            case (funct3_s)
                SH:      misaligned_s = (addr_offset_in == 2'b11);
                default: misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
        mem_op_s = run_s && (is_load_s || is_store_s) && !misaligned_s;
    end

    // Cache request: driven straight from the held EX/MA values so it stays stable in WAIT
    always_comb begin
        data_read  = mem_op_s && is_load_s;
        data_write = mem_op_s && is_store_s;
        data_mbe   = mem_byte_enable_in;
        data_addr  = {alu_in[31:2], 2'b00};
        data_wdata = rs2_in << {addr_offset_in, 3'b000};
        MA_stall   = mem_op_s && !data_resp;
    end

    memory_access_load_align u_load_align (
        .rdata  (data_rdata),
        .offset (addr_offset_in),
        .funct3 (funct3_s),
        .result (load_data_s)
    );

    // Pick the value written back: load data, comparator bit or ALU result
    always_comb begin
        if (misaligned_s) begin
            wb_data_s = 32'h0000_0000;
        end else if (is_load_s) begin
            wb_data_s = load_data_s;
        end else if (is_slt_s) begin
            wb_data_s = {31'h0000_0000, br_en_in};
        end else begin
            wb_data_s = alu_in;
        end
    end

    // Handshake next state: WAIT until the single completion pulse
    always_comb begin
        case (state_r)
            MA_IDLE: state_next_s = (mem_op_s && !data_resp) ? MA_WAIT : MA_IDLE;
            MA_WAIT: state_next_s = data_resp ? MA_IDLE : MA_WAIT;
            default: state_next_s = MA_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MA_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // MA/WB pipeline register: advances whenever MA is not stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_r      <= '0;
            mem_wb_data_r <= 32'h0000_0000;
            instruction_r <= 32'h0000_0000;
            pc_r          <= 32'h0000_0000;
            misalign_r    <= 1'b0;
        end else if (!MA_stall) begin
            mem_wb_r              <= ctrl_word_in;
            mem_wb_r.load_regfile <= ctrl_word_in.load_regfile && !misaligned_s;
            mem_wb_data_r         <= wb_data_s;
            instruction_r         <= instruction_in;
            pc_r                  <= PC_in;
            misalign_r            <= misaligned_s && run_s;
        end else begin
            misalign_r <= 1'b0;
        end
    end

    // Stall-cycle counter, sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_r <= '0;
        end else if (MA_stall && (stall_cycles_r != {PERF_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign mem_wb          = mem_wb_r;
    assign mem_wb_data     = mem_wb_data_r;
    assign instruction_out = instruction_r;
    assign PC_out          = pc_r;
    assign misalign        = misalign_r;
    assign stall_cycles    = stall_cycles_r;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MA stage; counter width shrunk to reach saturation.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int PW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    rv32i_control_word ctrl_word_in;
    logic [31:0]       instruction_in, PC_in, alu_in, rs2_in;
    logic              br_en_in;
    logic [3:0]        mem_byte_enable_in;
    logic [1:0]        addr_offset_in;
    logic              data_read, data_write;
    logic [3:0]        data_mbe;
    logic [31:0]       data_addr, data_wdata, data_rdata;
    logic              data_resp;
    logic              MA_stall, misalign;
    rv32i_control_word mem_wb;
    logic [31:0]       mem_wb_data, instruction_out, PC_out;
    logic [PW-1:0]     stall_cycles;

    int checks = 0;
    int errors = 0;

    memory_access #(.PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in),
        .PC_in(PC_in), .alu_in(alu_in), .rs2_in(rs2_in), .br_en_in(br_en_in),
        .mem_byte_enable_in(mem_byte_enable_in), .addr_offset_in(addr_offset_in),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_resp(data_resp), .MA_stall(MA_stall), .misalign(misalign), .mem_wb(mem_wb),
        .mem_wb_data(mem_wb_data), .instruction_out(instruction_out), .PC_out(PC_out),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [3:0] mbe, input logic br);
        ctrl_word_in.opcode       = op;
        ctrl_word_in.funct3       = f3;
        ctrl_word_in.load_regfile = (op != OP_STORE);
        ctrl_word_in.rd           = 5'd1;
        instruction_in            = {17'h0_0000, f3, 5'd1, op};
        PC_in                     = 32'h0000_0100;
        alu_in                    = alu;
        rs2_in                    = rs2;
        mem_byte_enable_in        = mbe;
        addr_offset_in            = alu[1:0];
        br_en_in                  = br;
    endtask

    task automatic nop();
        drive(OP_IMM, 3'b000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0);
    endtask

    initial begin
        data_resp  = 1'b0;
        data_rdata = 32'h0000_0000;
        nop();
        step(); step();
        chk("rst_data_read", {31'h0, data_read}, 32'h0);
        chk("rst_wb_data", mem_wb_data, 32'h0);
        chk("rst_stall_cnt", {29'h0, stall_cycles}, 32'h0);
        rst = 1'b1;
        step(); step(); step();

        // reset in the middle of an access
        drive(OP_LOAD, LW, 32'h0000_3000, 32'h0, 4'b1111, 1'b0);
        #1;
        chk("wait_data_read", {31'h0, data_read}, 32'h1);
        step();
        chk("wait_stall", {31'h0, MA_stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_data_read", {31'h0, data_read}, 32'h0);
        chk("midrst_stall", {31'h0, MA_stall}, 32'h0);
        chk("midrst_stall_cnt", {29'h0, stall_cycles}, 32'h0);
        chk("midrst_misalign", {31'h0, misalign}, 32'h0);
        nop();
        rst = 1'b1;
        step(); step(); step();

        // lb with three wait cycles
        drive(OP_LOAD, LB, 32'h0000_1003, 32'h0, 4'b1000, 1'b0);
        #1;
        chk("lb_addr", data_addr, 32'h0000_1000);
        chk("lb_read", {31'h0, data_read}, 32'h1);
        chk("lb_stall0", {31'h0, MA_stall}, 32'h1);
        step(); step(); step();
        chk("lb_stall3", {31'h0, MA_stall}, 32'h1);
        chk("lb_hold", mem_wb_data, 32'h0);
        data_resp  = 1'b1;
        data_rdata = 32'h80FF_1234;
        #1;
        chk("lb_resp_stall", {31'h0, MA_stall}, 32'h0);
        step();
        data_resp = 1'b0;
        chk("lb_data", mem_wb_data, 32'hFFFF_FF80);
        chk("lb_stall_cnt", {29'h0, stall_cycles}, 32'h3);

        // lhu answered in the same cycle
        drive(OP_LOAD, LHU, 32'h0000_1002, 32'h0, 4'b1100, 1'b0);
        data_resp  = 1'b1;
        data_rdata = 32'h8001_0000;
        #1;
        chk("lhu_stall", {31'h0, MA_stall}, 32'h0);
        step();
        chk("lhu_data", mem_wb_data, 32'h0000_8001);
        chk("lhu_stall_cnt", {29'h0, stall_cycles}, 32'h3);

        // sb lane alignment
        drive(OP_STORE, SB, 32'h0000_2002, 32'h0000_00AB, 4'b0100, 1'b0);
        #1;
        chk("sb_addr", data_addr, 32'h0000_2000);
        chk("sb_mbe", {28'h0, data_mbe}, 32'h4);
        chk("sb_wdata", data_wdata, 32'h00AB_0000);
        chk("sb_write", {31'h0, data_write}, 32'h1);
        chk("sb_read", {31'h0, data_read}, 32'h0);
        step();
        data_resp = 1'b0;

        // misaligned lw is dropped
        drive(OP_LOAD, LW, 32'h0000_1001, 32'h0, 4'b1111, 1'b0);
        #1;
        chk("mis_read", {31'h0, data_read}, 32'h0);
        chk("mis_stall", {31'h0, MA_stall}, 32'h0);
        step();
        chk("mis_flag", {31'h0, misalign}, 32'h1);
        chk("mis_data", mem_wb_data, 32'h0);
        chk("mis_regwrite", {31'h0, mem_wb.load_regfile}, 32'h0);
        drive(OP_IMM, 3'b000, 32'h0000_0007, 32'h0, 4'b0000, 1'b0);
        step();
        chk("mis_flag_clear", {31'h0, misalign}, 32'h0);
        chk("addi_data", mem_wb_data, 32'h0000_0007);

        // slt takes the comparator bit
        drive(OP_REG, F3_SLT, 32'h0000_FFFF, 32'h0, 4'b0000, 1'b1);
        step();
        chk("slt_data", mem_wb_data, 32'h0000_0001);

        // fresh counter, then add followed by lw with two wait cycles
        rst = 1'b0;
        #1;
        rst = 1'b1;
        step(); step(); step();
        drive(OP_REG, 3'b000, 32'h0000_0055, 32'h0, 4'b0000, 1'b0);
        step();
        chk("add_data", mem_wb_data, 32'h0000_0055);
        drive(OP_LOAD, LW, 32'h0000_4000, 32'h0, 4'b1111, 1'b0);
        step();
        chk("lw_hold1", mem_wb_data, 32'h0000_0055);
        step();
        chk("lw_hold2", mem_wb_data, 32'h0000_0055);
        data_resp  = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        step();
        data_resp = 1'b0;
        chk("lw_data", mem_wb_data, 32'hDEAD_BEEF);
        chk("lw_stall_cnt", {29'h0, stall_cycles}, 32'h2);

        // counter saturation: 2 + 6 stalls exceeds 3-bit range
        drive(OP_LOAD, LW, 32'h0000_4004, 32'h0, 4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) step();
        chk("sat_cnt", {29'h0, stall_cycles}, 32'h7);
        data_resp = 1'b1;
        step();
        data_resp = 1'b0;
        nop();
        step();
        chk("sat_cnt_hold", {29'h0, stall_cycles}, 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
